// File: rtl/button_pulse_array.sv
// Multi-channel push-button front end: synchronise, edge-detect and lockout-debounce
// each pin into a single-cycle pulse, with optional hold-to-repeat per channel.
module button_pulse_array #(
    parameter int CHANNELS       = 3,
    parameter int LOCKOUT        = 15,
    parameter int SHARED_LOCKOUT = 1,
    parameter int ACTIVE_LOW     = 1,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_PERIOD  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    input  logic                repeat_en,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] held,
    output logic                busy
);

    localparam int LW    = $clog2(LOCKOUT + 1);
    localparam int HMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW    = $clog2(HMAX + 1);
    localparam int NLOCK = (SHARED_LOCKOUT != 0) ? 1 : CHANNELS;

    localparam logic [CHANNELS-1:0] IDLE_LVL    = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [LW-1:0]       LOCK_LOAD   = LW'(LOCKOUT);
    localparam logic [HW-1:0]       HOLD_DELAY  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]       HOLD_PERIOD = HW'(REPEAT_PERIOD);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } rep_state_t;

    logic [CHANNELS-1:0] r_sync1, r_sync2, r_p_d, r_pulse;
    logic [CHANNELS-1:0] w_p, w_edge, w_accept, w_rep;
    logic [NLOCK-1:0]    w_lock_idle, w_lock_nz_next;
    logic [1:0]          r_warm;
    logic                r_busy;

    assign w_p = r_sync2 ^ IDLE_LVL;

    // Edges are masked until the synchroniser holds real pin data and p_d has
    // caught up, so a button held through reset never fires on release of rst.
    assign w_edge = (r_warm == 2'd3) ? (w_p & ~r_p_d) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= IDLE_LVL;
            r_sync2 <= IDLE_LVL;
            r_p_d   <= '0;
            r_pulse <= '0;
            r_warm  <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_p_d   <= w_p;
            r_pulse <= w_accept | w_rep;
            r_busy  <= |w_lock_nz_next;
            if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
        end
    end

    for (genvar k = 0; k < NLOCK; k++) begin : g_lock
        logic [LW-1:0] r_cnt;
        logic          w_load;

        if (SHARED_LOCKOUT != 0) begin : g_shared
            assign w_load = |w_accept;
        end else begin : g_own
            assign w_load = w_accept[k];
        end

        assign w_lock_idle[k]    = (r_cnt == '0);
        assign w_lock_nz_next[k] = w_load | (r_cnt > LW'(1));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                r_cnt <= '0;
            else if (w_load)         r_cnt <= LOCK_LOAD;
            else if (r_cnt != '0)    r_cnt <= r_cnt - LW'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        localparam int LI = (SHARED_LOCKOUT != 0) ? 0 : i;

        rep_state_t    r_state, w_state_next;
        logic [HW-1:0] r_hold, w_hold_next;
        logic          w_rep_i;

        assign w_accept[i] = w_edge[i] & w_lock_idle[LI];
        assign w_rep[i]    = w_rep_i;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_state <= S_IDLE;
                r_hold  <= '0;
            end else begin
                r_state <= w_state_next;
                r_hold  <= w_hold_next;
            end
        end

        // The counter never rests at 0 while armed: a value of 1 means the
        // repeat fires on this edge and the period reloads.
        always_comb begin
            w_state_next = r_state;
            w_hold_next  = r_hold;
            w_rep_i      = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept[i] && repeat_en) begin
                        w_state_next = S_ARMED;
                        w_hold_next  = HOLD_DELAY;
                    end
                end
                S_ARMED: begin
                    if (!w_p[i] || !repeat_en) begin
                        w_state_next = S_IDLE;
                        w_hold_next  = '0;
                    end else if (r_hold <= HW'(1)) begin
                        w_rep_i     = 1'b1;
                        w_hold_next = HOLD_PERIOD;
                    end else begin
                        w_hold_next = r_hold - HW'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_hold_next  = '0;
                end
            endcase
        end
    end

    assign pulse = r_pulse;
    assign held  = r_p_d;
    assign busy  = r_busy;

endmodule

// File: tb/tb_button_pulse_array.sv
// Directed bench for button_pulse_array: one shared-lockout and one per-channel
// instance see the same pins; expected pulse timings are hand-derived.
module tb_button_pulse_array;

    logic       clk;
    logic       rst;
    logic [2:0] btn;
    logic       repeat_en;
    logic [2:0] pulse_s, held_s, pulse_p, held_p;
    logic       busy_s, busy_p;

    int n_checks = 0;
    int n_pass   = 0;

    button_pulse_array #(
        .CHANNELS(3), .LOCKOUT(4), .SHARED_LOCKOUT(1), .ACTIVE_LOW(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_shared (
        .clk(clk), .rst(rst), .btn(btn), .repeat_en(repeat_en),
        .pulse(pulse_s), .held(held_s), .busy(busy_s)
    );

    button_pulse_array #(
        .CHANNELS(3), .LOCKOUT(4), .SHARED_LOCKOUT(0), .ACTIVE_LOW(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_perch (
        .clk(clk), .rst(rst), .btn(btn), .repeat_en(repeat_en),
        .pulse(pulse_p), .held(held_p), .busy(busy_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] b);
        btn = b;
        rst = 1'b0;
        tick();
        tick();
        chk("rst_pulse", {29'd0, pulse_s}, 32'd0);
        chk("rst_held",  {29'd0, held_s},  32'd0);
        chk("rst_busy",  {31'd0, busy_s},  32'd0);
        rst = 1'b1;
        repeat (4) tick();
    endtask

    // Release btn0 two cycles after the press, then press again at 'repress'.
    // The second press is accepted only once the lockout has fully drained.
    task automatic press_gap(input int repress);
        logic [2:0] exp;
        do_reset(3'b111);
        btn = 3'b110;
        for (int t = 1; t <= 14; t++) begin
            tick();
            exp = ((t == 3) || (repress >= 5 && t == repress + 3)) ? 3'b001 : 3'b000;
            chk($sformatf("gap%0d_t%0d", repress, t), {29'd0, pulse_s}, {29'd0, exp});
            if (t == 2) btn = 3'b111;
            if (t == repress) btn = 3'b110;
        end
        btn = 3'b111;
    endtask

    function automatic bit in_list(input int t, input int n, input int list[8]);
        for (int j = 0; j < n; j++) if (list[j] == t) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int cnt;
        int rep_all[8]  = '{3, 13, 16, 19, 22, 25, 28, 31};
        int rep_stop[8] = '{3, 13, 16, 0, 0, 0, 0, 0};
        logic [2:0] exp;

        rst = 1'b0;
        btn = 3'b111;
        repeat_en = 1'b0;

        // Single clean press: 3-edge latency, 4-cycle busy, held follows.
        do_reset(3'b111);
        btn = 3'b110;
        tick(); chk("s1_lat1", {29'd0, pulse_s}, 32'd0);
        tick(); chk("s1_lat2", {29'd0, pulse_s}, 32'd0);
        tick();
        chk("s1_pulse", {29'd0, pulse_s}, 32'd1);
        chk("s1_held",  {29'd0, held_s},  32'd1);
        chk("s1_busy0", {31'd0, busy_s},  32'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("s1_busy%0d", i), {31'd0, busy_s}, 32'd1);
            chk($sformatf("s1_once%0d", i), {29'd0, pulse_s}, 32'd0);
        end
        tick(); chk("s1_busy_end", {31'd0, busy_s}, 32'd0);
        btn = 3'b111;

        // Bounce low/high/low: only one pulse.
        do_reset(3'b111);
        btn = 3'b110; tick();
        btn = 3'b111; tick();
        btn = 3'b110;
        cnt = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            cnt += int'(pulse_s[0]);
        end
        chk("s2_bounce_cnt", cnt, 32'd1);
        btn = 3'b111;

        // Re-press spacing at the lockout boundary.
        press_gap(4);
        press_gap(5);

        // Press on btn1 two cycles after btn0 is accepted.
        do_reset(3'b111);
        btn = 3'b110;
        for (int t = 1; t <= 10; t++) begin
            tick();
            exp = (t == 3) ? 3'b001 : 3'b000;
            chk($sformatf("s3_shared_t%0d", t), {29'd0, pulse_s}, {29'd0, exp});
            exp = (t == 3) ? 3'b001 : ((t == 5) ? 3'b010 : 3'b000);
            chk($sformatf("s3_perch_t%0d", t), {29'd0, pulse_p}, {29'd0, exp});
            if (t == 2) btn = 3'b100;
        end
        btn = 3'b111;

        // Simultaneous press on btn0 and btn2.
        do_reset(3'b111);
        btn = 3'b010;
        for (int t = 1; t <= 6; t++) begin
            tick();
            exp = (t == 3) ? 3'b101 : 3'b000;
            chk($sformatf("s4_shared_t%0d", t), {29'd0, pulse_s}, {29'd0, exp});
            chk($sformatf("s4_perch_t%0d", t),  {29'd0, pulse_p}, {29'd0, exp});
        end
        btn = 3'b111;

        // Hold btn2 for 30 cycles with repeat enabled.
        do_reset(3'b111);
        repeat_en = 1'b1;
        btn = 3'b011;
        for (int t = 1; t <= 40; t++) begin
            tick();
            exp = in_list(t, 8, rep_all) ? 3'b100 : 3'b000;
            chk($sformatf("s5_rep_t%0d", t), {29'd0, pulse_s}, {29'd0, exp});
            if (t == 30) btn = 3'b111;
        end

        // Drop repeat_en mid-hold.
        do_reset(3'b111);
        repeat_en = 1'b1;
        btn = 3'b011;
        for (int t = 1; t <= 30; t++) begin
            tick();
            exp = in_list(t, 3, rep_stop) ? 3'b100 : 3'b000;
            chk($sformatf("s5_stop_t%0d", t), {29'd0, pulse_s}, {29'd0, exp});
            if (t == 17) repeat_en = 1'b0;
        end
        repeat_en = 1'b0;
        btn = 3'b111;

        // btn1 held through reset release: silent until released and re-pressed.
        btn = 3'b101;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            cnt += int'(|pulse_s);
        end
        chk("s6_held_silent", cnt, 32'd0);
        chk("s6_held_level", {29'd0, held_s}, 32'd2);
        btn = 3'b111;
        repeat (5) tick();
        btn = 3'b101;
        tick(); tick();
        chk("s6_repress_pre", {29'd0, pulse_s}, 32'd0);
        tick();
        chk("s6_repress", {29'd0, pulse_s}, 32'd2);

        // Reset asserted in the cycle of an accepted pulse aborts at once.
        do_reset(3'b111);
        btn = 3'b110;
        tick(); tick(); tick();
        chk("s7_pulse", {29'd0, pulse_s}, 32'd1);
        chk("s7_busy",  {31'd0, busy_s},  32'd1);
        rst = 1'b0;
        #1;
        chk("s7_abort_pulse", {29'd0, pulse_s}, 32'd0);
        chk("s7_abort_busy",  {31'd0, busy_s},  32'd0);
        chk("s7_abort_held",  {29'd0, held_s},  32'd0);
        btn = 3'b111;
        tick();
        rst = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
